// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding, grant identifiers and default parameter values
// for the single-port memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   localparam int ADDR_W_DEF     = 32;
   localparam int DATA_W_DEF     = 32;
   localparam int STREAK_MAX_DEF = 4;
   localparam int TIMEOUT_DEF    = 255;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the arbiter, the fetch/memory pipeline stages and
// the shared memory. The arbiter uses the slave view, the environment the master view.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   // i_req/d_req are levels held until their one-cycle ack; mem_req is held
   // until a one-cycle mem_ack, or dropped when the watchdog abandons the access.
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_mem;
   logic              bus_err;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, bus_err
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
             stall_if, stall_mem, bus_err
   );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Handshake watchdog: counts cycles spent waiting on the memory and flags
// the cycle after which the access has to be abandoned.
module mem_arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic start_i,
   input  logic run_i,
   output logic expired_o
);
   localparam logic [7:0] LIMIT = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

   logic [7:0] timer_q, timer_d;

   always_comb begin
      timer_d = timer_q;
      if (start_i) begin
         timer_d = '0;
      end else if (run_i) begin
         timer_d = timer_q + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   // A zero TIMEOUT disables the watchdog entirely.
   assign expired_o = (TIMEOUT != 0) && run_i && (timer_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch reads and data reads/writes onto one variable-latency memory
// port, with fetch starvation protection and a handshake watchdog.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STREAK_MAX = STREAK_MAX_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic   clock,
   input  logic   reset,
   mem_port_arbiter_if.slave bus,
   output state_t state_o
);
   localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic [3:0]        streak_q, streak_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              err_q, err_d;
   logic              busy, grant, expired, i_ack, d_ack;

   assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

   mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clock     (clock),
      .reset     (reset),
      .start_i   (grant),
      .run_i     (busy),
      .expired_o (expired)
   );

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      streak_d    = streak_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      err_d       = err_q;
      grant       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               grant = 1'b1;
               // Data normally wins; fetch takes the port once data has won
               // STREAK_MAX times in a row while fetch was waiting.
               if (bus.d_req && !(bus.i_req && (streak_q == STREAK_LIM))) begin
                  gnt_d       = GNT_D;
                  state_d     = BUSY_D;
                  mem_we_d    = bus.d_we;
                  mem_addr_d  = bus.d_addr;
                  mem_wdata_d = bus.d_wdata;
                  streak_d    = bus.i_req ? streak_q + 4'd1 : 4'd0;
               end else begin
                  gnt_d       = GNT_I;
                  state_d     = BUSY_I;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = bus.i_addr;
                  mem_wdata_d = '0;
                  streak_d    = 4'd0;
               end
            end
         end
         BUSY_I, BUSY_D: begin
            if (bus.mem_ack) begin
               state_d = RESP;
               if (state_q == BUSY_I) begin
                  i_rdata_d = bus.mem_rdata;
               end else if (!mem_we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
            end else if (expired) begin
               state_d = RESP;
               err_d   = 1'b1;
               if (state_q == BUSY_I) begin
                  i_rdata_d = '0;
               end else begin
                  d_rdata_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         gnt_q       <= GNT_I;
         streak_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         streak_q    <= streak_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
      end
   end

   assign i_ack         = (state_q == RESP) && (gnt_q == GNT_I);
   assign d_ack         = (state_q == RESP) && (gnt_q == GNT_D);
   assign bus.i_ack     = i_ack;
   assign bus.d_ack     = d_ack;
   assign bus.bus_err   = (state_q == RESP) && err_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_req   = busy;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.stall_if  = bus.i_req & ~i_ack;
   assign bus.stall_mem = bus.d_req & ~d_ack;
   assign state_o       = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// phase, all checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SMAX = 4;
   localparam int TMO = 8;
   localparam int P_IDLE = 0;
   localparam int P_BUSY = 1;
   localparam int P_RESP = 2;
   localparam int M_OFF = 0;
   localparam int M_HOLD = 1;
   localparam int M_RAND = 2;
   localparam int M_DRAIN = 3;

   logic   clock = 1'b0;
   logic   reset = 1'b1;
   state_t dbg_state;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STREAK_MAX(SMAX), .TIMEOUT(TMO)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus),
      .state_o (dbg_state)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: phase of the current access and what it should return
   int          ph, age, streak, cur_delay;
   bit          who, x_we, m_err;
   logic [AW-1:0] x_addr;
   logic [DW-1:0] x_wdata, exp_i, exp_d;
   bit          last_ack;
   logic [DW-1:0] last_rdata;

   // memory responder and requester configuration
   int          dly_lo, dly_hi;
   bit          never_ack, spurious, fix_en;
   logic [DW-1:0] fix_rdata;
   int          i_mode, d_mode;

   // raw observations of the DUT for directed checks
   int          cyc;
   bit          prev_req, saw_err;
   int          busy_run, last_run;
   int          i_ack_t[$];
   logic [0:0]  obs_q[$];
   logic [0:0]  exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ph = P_IDLE; age = 0; streak = 0; m_err = 0; who = 0;
      exp_i = '0; exp_d = '0; last_ack = 0; prev_req = 0; busy_run = 0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      bus.mem_ack = 1'b0;
      #1;
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_i_ack", bus.i_ack, 0);
      chk("rst_d_ack", bus.d_ack, 0);
      chk("rst_bus_err", bus.bus_err, 0);
      chk("rst_i_rdata", bus.i_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      chk("rst_stall_mem", bus.stall_mem, bus.d_req);
      chk("rst_state", dbg_state, IDLE);
      repeat (n) @(negedge clock);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic observe();
      if (bus.mem_req && !prev_req) obs_q.push_back(bus.mem_addr == 32'h100);
      if (bus.mem_req) busy_run++;
      else if (prev_req) begin
         last_run = busy_run;
         busy_run = 0;
      end
      if (bus.i_ack) i_ack_t.push_back(cyc);
      if (bus.bus_err) saw_err = 1;
      prev_req = bus.mem_req;
   endtask

   // Advances the model by the posedge just taken, using the inputs the DUT saw there.
   task automatic model_step();
      bit take_d;
      take_d = 0;
      case (ph)
         P_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               take_d = bus.d_req && !(bus.i_req && streak == SMAX);
               if (take_d) begin
                  if (bus.i_req) begin
                     if (streak < SMAX) streak++;
                  end else streak = 0;
                  who = 1; x_addr = bus.d_addr; x_we = bus.d_we; x_wdata = bus.d_wdata;
               end else begin
                  streak = 0;
                  who = 0; x_addr = bus.i_addr; x_we = 0; x_wdata = '0;
               end
               ph = P_BUSY;
               age = 0;
               cur_delay = never_ack ? -1 : int'($urandom_range(dly_hi, dly_lo));
            end
         end
         P_BUSY: begin
            if (last_ack) begin
               ph = P_RESP;
               m_err = 0;
               if (!who) exp_i = last_rdata;
               else if (!x_we) exp_d = last_rdata;
            end else if (age == TMO - 1) begin
               ph = P_RESP;
               m_err = 1;
               if (!who) exp_i = '0;
               else exp_d = '0;
            end else age++;
         end
         default: begin
            ph = P_IDLE;
            m_err = 0;
         end
      endcase
   endtask

   task automatic check_cycle();
      bit e_i, e_d;
      e_i = (ph == P_RESP) && !who;
      e_d = (ph == P_RESP) && who;
      chk("mem_req", bus.mem_req, ph == P_BUSY);
      if (ph == P_BUSY) begin
         chk("mem_addr", bus.mem_addr, x_addr);
         chk("mem_we", bus.mem_we, x_we);
         chk("mem_wdata", bus.mem_wdata, x_wdata);
      end
      chk("i_ack", bus.i_ack, e_i);
      chk("d_ack", bus.d_ack, e_d);
      chk("bus_err", bus.bus_err, (ph == P_RESP) && m_err);
      chk("i_rdata", bus.i_rdata, exp_i);
      chk("d_rdata", bus.d_rdata, exp_d);
      chk("stall_if", bus.stall_if, bus.i_req && !e_i);
      chk("stall_mem", bus.stall_mem, bus.d_req && !e_d);
   endtask

   task automatic drive_mem();
      last_ack = 0;
      if (ph == P_BUSY && age == cur_delay) last_ack = 1;
      else if (ph != P_BUSY && spurious && $urandom_range(0, 3) == 0) last_ack = 1;
      last_rdata = fix_en ? fix_rdata : $urandom;
      bus.mem_ack = last_ack;
      bus.mem_rdata = last_rdata;
   endtask

   task automatic drive_reqs();
      bit i_done, d_done;
      i_done = (ph == P_RESP) && !who;
      d_done = (ph == P_RESP) && who;
      case (i_mode)
         M_OFF:   bus.i_req = 0;
         M_HOLD:  bus.i_req = 1;
         M_DRAIN: if (i_done) bus.i_req = 0;
         default: if (!bus.i_req || i_done) begin
            bus.i_req = ($urandom_range(0, 2) == 0);
            bus.i_addr = $urandom;
         end
      endcase
      case (d_mode)
         M_OFF:   bus.d_req = 0;
         M_HOLD:  bus.d_req = 1;
         M_DRAIN: if (d_done) bus.d_req = 0;
         default: if (!bus.d_req || d_done) begin
            bus.d_req = ($urandom_range(0, 2) == 0);
            bus.d_we = 1'($urandom_range(0, 1));
            bus.d_addr = $urandom;
            bus.d_wdata = $urandom;
         end
      endcase
   endtask

   task automatic tick();
      @(negedge clock);
      cyc++;
      observe();
      model_step();
      check_cycle();
      drive_mem();
      drive_reqs();
   endtask

   task automatic drain();
      int n;
      n = 0;
      i_mode = M_DRAIN;
      d_mode = M_DRAIN;
      while (!(ph == P_IDLE && !bus.i_req && !bus.d_req) && n < 2000) begin
         tick();
         n++;
      end
      chk("drain_bound", n < 2000, 1);
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish within time limit");
      $fatal(1, "global timeout");
   end

   initial begin
      int c0, got;
      bus.i_req = 0; bus.i_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_ack = 0; bus.mem_rdata = '0;
      i_mode = M_OFF; d_mode = M_OFF;
      dly_lo = 1; dly_hi = 1; never_ack = 0; spurious = 0; fix_en = 0; fix_rdata = '0;
      cyc = 0; saw_err = 0; last_run = 0;
      #2;
      do_reset(2);

      // single fetch, memory answers on the third BUSY cycle
      fix_en = 1; fix_rdata = 32'h8C220004; dly_lo = 2; dly_hi = 2;
      i_ack_t.delete();
      c0 = cyc;
      bus.i_req = 1; bus.i_addr = 32'h40; i_mode = M_DRAIN;
      drain();
      chk("single_i_rdata", bus.i_rdata, 32'h8C220004);
      chk("single_busy_cycles", last_run, 3);
      chk("single_ack_count", i_ack_t.size(), 1);
      if (i_ack_t.size() > 0) chk("single_latency", i_ack_t[0] - c0, 4);

      // store: write data held on the port, load data untouched
      fix_en = 0; dly_lo = 1; dly_hi = 4;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
      d_mode = M_DRAIN;
      drain();
      chk("store_d_rdata", bus.d_rdata, 0);

      // contention with both requests held: data wins four times, then fetch
      dly_lo = 0; dly_hi = 2;
      bus.d_we = 0; bus.d_addr = 32'h100; bus.i_addr = 32'h40;
      bus.i_req = 1; bus.d_req = 1; i_mode = M_HOLD; d_mode = M_HOLD;
      obs_q.delete();
      exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 300 && obs_q.size() < 10; k++) tick();
      chk("contention_grants", obs_q.size(), 10);
      for (int k = 0; k < 10 && k < obs_q.size(); k++) chk("contention_order", obs_q[k], exp_q[k]);
      drain();

      // watchdog: no mem_ack at all
      never_ack = 1; saw_err = 0;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; d_mode = M_DRAIN;
      drain();
      chk("timeout_busy_cycles", last_run, TMO);
      chk("timeout_bus_err", saw_err, 1);
      chk("timeout_d_rdata", bus.d_rdata, 0);

      // mem_ack on the last allowed cycle wins over the watchdog
      never_ack = 0; dly_lo = TMO - 1; dly_hi = TMO - 1; saw_err = 0;
      fix_en = 1; fix_rdata = 32'h12345678;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h204; d_mode = M_DRAIN;
      drain();
      chk("late_ack_busy_cycles", last_run, TMO);
      chk("late_ack_no_err", saw_err, 0);
      chk("late_ack_d_rdata", bus.d_rdata, 32'h12345678);

      // reset in the middle of a data access, request still held afterwards
      fix_en = 0; dly_lo = 5; dly_hi = 5;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300; d_mode = M_HOLD;
      for (int k = 0; k < 10 && ph != P_BUSY; k++) tick();
      chk("rst_mid_reached_busy", ph == P_BUSY, 1);
      tick();
      tick();
      do_reset(2);
      got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
         tick();
         if (bus.d_ack) got = 1;
      end
      chk("rst_resume_ack", got, 1);
      drain();

      // back-to-back fetches with the fastest memory
      dly_lo = 0; dly_hi = 0;
      i_ack_t.delete();
      c0 = cyc;
      bus.i_req = 1; bus.i_addr = 32'h80; i_mode = M_HOLD;
      repeat (30) tick();
      chk("b2b_ack_count", i_ack_t.size(), 10);
      if (i_ack_t.size() > 0) chk("b2b_first_latency", i_ack_t[0] - c0, 2);
      for (int k = 1; k < i_ack_t.size(); k++) chk("b2b_gap", i_ack_t[k] - i_ack_t[k-1], 3);
      drain();

      // random traffic, random latencies including timeouts, stray mem_acks
      dly_lo = 0; dly_hi = TMO + 1; spurious = 1;
      i_mode = M_RAND; d_mode = M_RAND;
      repeat (3000) tick();
      spurious = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
